lsu_dcache: RTL and testbench

//  Parametrised direct-mapped, write-through, no-write-allocate data cache with integrated load/store alignment.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/lsu_dcache_if.sv | 24 ++
 rtl/lsu_align.sv | 87 ++++++++
 rtl/lsu_dcache.sv | 178 +++++++++++++++++
 tb/tb_lsu_dcache.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, funct3 codes and address-field helpers for lsu_dcache
package cache_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_BEAT, WR_REQ} cache_state_t;

    function automatic int word_bits(input int wpl);
        return $clog2(wpl);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int aw, input int sets, input int wpl);
        return aw - 2 - word_bits(wpl) - index_bits(sets);
    endfunction

endpackage

// File: rtl/lsu_dcache_if.sv
// rtl/lsu_dcache_if.sv - memory-side bus between lsu_dcache and main memory
interface lsu_dcache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - RV32I load extraction/extension and store lane placement
module lsu_align
    import cache_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_sh,
    output logic        misaligned,
    output logic        op_valid
);

    logic [31:0] rshift;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rshift = rword >> {addr_lo, 3'b000};
    assign rbyte  = rshift[7:0];
    assign rhalf  = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        rdata      = '0;
        strb       = '0;
        wdata_sh   = '0;
        misaligned = 1'b0;
        op_valid   = 1'b0;
        if (we) begin
            case (funct3)
                SB: begin
                    op_valid = 1'b1;
                    strb     = 4'b0001 << addr_lo;
                    wdata_sh = {4{wdata[7:0]}};
                end
                SH: begin
                    op_valid   = 1'b1;
                    misaligned = addr_lo[0];
                    strb       = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata_sh   = {2{wdata[15:0]}};
                end
                SW: begin
                    op_valid   = 1'b1;
                    misaligned = (addr_lo != 2'b00);
                    strb       = 4'b1111;
                    wdata_sh   = wdata;
                end
                default: ;
            endcase
        end else begin
            case (funct3)
                LB: begin
                    op_valid = 1'b1;
                    rdata    = {{24{rbyte[7]}}, rbyte};
                end
                LBU: begin
                    op_valid = 1'b1;
                    rdata    = {24'd0, rbyte};
                end
                LH: begin
                    op_valid   = 1'b1;
                    misaligned = addr_lo[0];
                    rdata      = {{16{rhalf[15]}}, rhalf};
                end
                LHU: begin
                    op_valid   = 1'b1;
                    misaligned = addr_lo[0];
                    rdata      = {16'd0, rhalf};
                end
                LW: begin
                    op_valid   = 1'b1;
                    misaligned = (addr_lo != 2'b00);
                    rdata      = rword;
                end
                default: ;
            endcase
        end
        // A misaligned access never touches the cache, so no lanes or data escape.
        if (misaligned) begin
            rdata = '0;
            strb  = '0;
        end
    end

endmodule

// File: rtl/lsu_dcache.sv
// rtl/lsu_dcache.sv - direct-mapped write-through no-write-allocate data cache with LSU alignment
module lsu_dcache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  cache_hit,
    output logic                  misaligned,
    lsu_dcache_if.master          mem
);

    localparam int WOFF_W = word_bits(WORDS_PER_LINE);
    localparam int IDX_W  = index_bits(SETS);
    localparam int TAG_W  = tag_bits(ADDR_WIDTH, SETS, WORDS_PER_LINE);
    localparam int LSB    = WOFF_W + 2;

    cache_state_t          state;
    logic [WOFF_W-1:0]     cnt;
    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS*WORDS_PER_LINE];

    logic [IDX_W-1:0]      req_idx;
    logic [WOFF_W-1:0]     req_woff;
    logic [TAG_W-1:0]      req_tag;
    logic [DATA_WIDTH-1:0] rword;
    logic                  hit_raw;

    logic [DATA_WIDTH-1:0] al_rdata;
    logic [3:0]            al_strb;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic                  al_mis;
    logic                  al_ok;

    logic                  idle_req;
    logic                  act;
    logic                  ld_hit;

    logic [IDX_W-1:0]      f_idx;
    logic [WOFF_W-1:0]     f_woff;
    logic [TAG_W-1:0]      f_tag;
    logic                  beat;
    logic                  last_beat;
    logic                  wr_hit;

    assign req_idx  = addr[LSB +: IDX_W];
    assign req_woff = addr[2 +: WOFF_W];
    assign req_tag  = addr[ADDR_WIDTH-1 -: TAG_W];
    assign rword    = data_mem[{req_idx, req_woff}];
    assign hit_raw  = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    lsu_align u_align (
        .we         (req_we),
        .funct3     (funct3),
        .addr_lo    (addr[1:0]),
        .rword      (rword),
        .wdata      (wdata),
        .rdata      (al_rdata),
        .strb       (al_strb),
        .wdata_sh   (al_wdata),
        .misaligned (al_mis),
        .op_valid   (al_ok)
    );

    assign idle_req   = !rst && req_valid && (state == IDLE);
    assign act        = idle_req && al_ok && !al_mis;
    assign ld_hit     = act && !req_we && hit_raw;
    assign cache_hit  = ld_hit;
    assign rdata      = ld_hit ? al_rdata : '0;
    assign misaligned = idle_req && al_mis;

    // The registered mem_addr doubles as the line/word pointer for the outstanding access.
    assign f_idx     = mem.mem_addr[LSB +: IDX_W];
    assign f_woff    = mem.mem_addr[2 +: WOFF_W];
    assign f_tag     = mem.mem_addr[ADDR_WIDTH-1 -: TAG_W];
    assign beat      = (state == RD_BEAT) && mem.mem_rvalid;
    assign last_beat = beat && (cnt == WOFF_W'(WORDS_PER_LINE - 1));
    assign wr_hit    = (state == WR_REQ) && mem.mem_gnt
                       && valid_q[f_idx] && (tag_mem[f_idx] == f_tag);

    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    stall = act && (req_we || !hit_raw);
                RD_REQ:  stall = 1'b1;
                RD_BEAT: stall = 1'b1;
                WR_REQ:  stall = !mem.mem_gnt;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            valid_q       <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (act && req_we) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b1;
                        mem.mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        mem.mem_wdata <= al_wdata;
                        mem.mem_wstrb <= al_strb;
                        state         <= WR_REQ;
                    end else if (act && !hit_raw) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= {addr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
                        mem.mem_wstrb <= '0;
                        state         <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        state       <= RD_BEAT;
                    end
                end
                RD_BEAT: begin
                    if (beat) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (last_beat) begin
                        valid_q[f_idx] <= 1'b1;
                        state          <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (beat) begin
                data_mem[{f_idx, cnt}] <= mem.mem_rdata;
            end
            if (last_beat) begin
                tag_mem[f_idx] <= f_tag;
            end
            if (wr_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem.mem_wstrb[b]) begin
                        data_mem[{f_idx, f_woff}][8*b +: 8] <= mem.mem_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_dcache.sv
// tb/tb_lsu_dcache.sv - directed self-checking bench for lsu_dcache
module tb_lsu_dcache;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        cache_hit;
    logic        misaligned;

    int checks = 0;
    int failures = 0;

    lsu_dcache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    lsu_dcache dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .cache_hit  (cache_hit),
        .misaligned (misaligned),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
    endtask

    task automatic set_req(input logic v, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = d;
    endtask

    // Plays main memory for a line refill; returns at the first non-stalled cycle.
    task automatic drive_refill(input int gnt_cycle, input logic [31:0] beats [4],
                                output int stall_n, output logic [31:0] addr_seen);
        int cyc = 0;
        int bidx = 0;
        int req_cyc = 0;
        bit granted = 0;
        stall_n = 0;
        addr_seen = 32'hxxxxxxxx;
        while (cyc < 50) begin
            mem_bus.mem_gnt    = 1'b0;
            mem_bus.mem_rvalid = 1'b0;
            if (mem_bus.mem_req && !granted) begin
                req_cyc++;
                addr_seen = mem_bus.mem_addr;
                if (req_cyc == gnt_cycle) begin
                    mem_bus.mem_gnt = 1'b1;
                    granted = 1;
                end
            end else if (granted && bidx < 4) begin
                mem_bus.mem_rvalid = 1'b1;
                mem_bus.mem_rdata  = beats[bidx];
                bidx++;
            end
            #1;
            if (!stall) break;
            stall_n++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        mem_bus.mem_rvalid = 1'b0;
    endtask

    // Plays main memory for a write; returns in the gnt cycle.
    task automatic drive_store(input int gnt_cycle, output int stall_n,
                               output logic [31:0] addr_seen, output logic [31:0] data_seen,
                               output logic [3:0] strb_seen, output logic we_seen);
        int cyc = 0;
        int req_cyc = 0;
        stall_n = 0;
        addr_seen = 32'hxxxxxxxx;
        data_seen = 32'hxxxxxxxx;
        strb_seen = 4'hx;
        we_seen = 1'bx;
        while (cyc < 50) begin
            mem_bus.mem_gnt = 1'b0;
            if (mem_bus.mem_req) begin
                req_cyc++;
                addr_seen = mem_bus.mem_addr;
                data_seen = mem_bus.mem_wdata;
                strb_seen = mem_bus.mem_wstrb;
                we_seen   = mem_bus.mem_we;
                if (req_cyc == gnt_cycle) mem_bus.mem_gnt = 1'b1;
            end
            #1;
            if (!stall) break;
            stall_n++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(1'b1, 1'b0, LW, 32'h100, 32'h0);
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'h0;
        @(negedge clk);
        next_cycle();
        #1;
        checks++;
        if (stall !== 1'b0 || cache_hit !== 1'b0 || misaligned !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs stall=%b hit=%b mis=%b rdata=%h required 0 0 0 0", stall, cache_hit, misaligned, rdata);
        end
        checks++;
        if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_we !== 1'b0 || mem_bus.mem_addr !== 32'h0
            || mem_bus.mem_wdata !== 32'h0 || mem_bus.mem_wstrb !== 4'h0) begin
            failures++;
            $display("FAIL reset_mem req=%b we=%b addr=%h wdata=%h strb=%b required all 0",
                     mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_wstrb);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_refill();
        logic [31:0] beats [4];
        int sn;
        logic [31:0] a_seen;
        beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33; beats[3] = 32'h44;
        set_req(1'b1, 1'b0, LW, 32'h100, 32'h0);
        #1;
        checks++;
        if (stall !== 1'b1 || cache_hit !== 1'b0) begin
            failures++;
            $display("FAIL miss_first_cycle stall=%b hit=%b required 1 0", stall, cache_hit);
        end
        drive_refill(2, beats, sn, a_seen);
        checks++;
        if (sn !== 7) begin
            failures++;
            $display("FAIL miss_stall_len got=%0d required 7", sn);
        end
        checks++;
        if (a_seen !== 32'h100) begin
            failures++;
            $display("FAIL miss_mem_addr got=%h required 00000100", a_seen);
        end
        checks++;
        if (rdata !== 32'h11 || cache_hit !== 1'b1 || mem_bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL refill_hit rdata=%h hit=%b req=%b required 00000011 1 0", rdata, cache_hit, mem_bus.mem_req);
        end
        next_cycle();
    endtask

    task automatic test_load_align();
        logic [2:0]  f3s [9];
        logic [31:0] as  [9];
        logic [31:0] exp [9];
        int sn;
        logic [31:0] a_s, d_s;
        logic [3:0] s_s;
        logic w_s;
        set_req(1'b1, 1'b0, LW, 32'h10C, 32'h0);
        #1;
        checks++;
        if (rdata !== 32'h44 || stall !== 1'b0 || cache_hit !== 1'b1) begin
            failures++;
            $display("FAIL hit_lw_10c rdata=%h stall=%b hit=%b required 00000044 0 1", rdata, stall, cache_hit);
        end
        next_cycle();
        set_req(1'b1, 1'b1, SW, 32'h10C, 32'h80FF7F01);
        drive_store(1, sn, a_s, d_s, s_s, w_s);
        checks++;
        if (sn !== 1 || a_s !== 32'h10C || d_s !== 32'h80FF7F01 || s_s !== 4'b1111 || w_s !== 1'b1) begin
            failures++;
            $display("FAIL sw_hit stall_n=%0d addr=%h wdata=%h strb=%b we=%b required 1 0000010c 80ff7f01 1111 1",
                     sn, a_s, d_s, s_s, w_s);
        end
        next_cycle();
        f3s[0] = LB;  as[0] = 32'h10C; exp[0] = 32'h00000001;
        f3s[1] = LB;  as[1] = 32'h10F; exp[1] = 32'hFFFFFF80;
        f3s[2] = LHU; as[2] = 32'h10E; exp[2] = 32'h000080FF;
        f3s[3] = LH;  as[3] = 32'h10E; exp[3] = 32'hFFFF80FF;
        f3s[4] = LBU; as[4] = 32'h10F; exp[4] = 32'h00000080;
        f3s[5] = LH;  as[5] = 32'h10C; exp[5] = 32'h00007F01;
        f3s[6] = LB;  as[6] = 32'h10D; exp[6] = 32'h0000007F;
        f3s[7] = LB;  as[7] = 32'h10E; exp[7] = 32'hFFFFFFFF;
        f3s[8] = LW;  as[8] = 32'h10C; exp[8] = 32'h80FF7F01;
        for (int i = 0; i < 9; i++) begin
            set_req(1'b1, 1'b0, f3s[i], as[i], 32'h0);
            #1;
            checks++;
            if (rdata !== exp[i] || stall !== 1'b0 || cache_hit !== 1'b1) begin
                failures++;
                $display("FAIL load_align[%0d] f3=%b addr=%h rdata=%h stall=%b hit=%b required %h 0 1",
                         i, f3s[i], as[i], rdata, stall, cache_hit, exp[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_store_merge();
        int sn;
        logic [31:0] a_s, d_s;
        logic [3:0] s_s;
        logic w_s;
        set_req(1'b1, 1'b1, SB, 32'h101, 32'h000000AB);
        drive_store(2, sn, a_s, d_s, s_s, w_s);
        checks++;
        if (sn !== 2 || a_s !== 32'h100 || d_s !== 32'hABABABAB || s_s !== 4'b0010) begin
            failures++;
            $display("FAIL sb_lanes stall_n=%0d addr=%h wdata=%h strb=%b required 2 00000100 abababab 0010", sn, a_s, d_s, s_s);
        end
        next_cycle();
        set_req(1'b1, 1'b0, LW, 32'h100, 32'h0);
        #1;
        checks++;
        if (rdata !== 32'h0000AB11 || stall !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL sb_merge rdata=%h stall=%b req=%b required 0000ab11 0 0", rdata, stall, mem_bus.mem_req);
        end
        next_cycle();
        set_req(1'b1, 1'b1, SH, 32'h106, 32'hFFFF1234);
        drive_store(1, sn, a_s, d_s, s_s, w_s);
        checks++;
        if (a_s !== 32'h104 || d_s !== 32'h12341234 || s_s !== 4'b1100) begin
            failures++;
            $display("FAIL sh_lanes addr=%h wdata=%h strb=%b required 00000104 12341234 1100", a_s, d_s, s_s);
        end
        next_cycle();
        set_req(1'b1, 1'b0, LW, 32'h104, 32'h0);
        #1;
        checks++;
        if (rdata !== 32'h12340022 || cache_hit !== 1'b1) begin
            failures++;
            $display("FAIL sh_merge rdata=%h hit=%b required 12340022 1", rdata, cache_hit);
        end
        next_cycle();
    endtask

    task automatic test_no_allocate();
        int sn;
        logic [31:0] a_s, d_s;
        logic [3:0] s_s;
        logic w_s;
        logic [31:0] beats [4];
        beats[0] = 32'hA0; beats[1] = 32'hA1; beats[2] = 32'hA2; beats[3] = 32'hA3;
        set_req(1'b1, 1'b1, SW, 32'h2000, 32'hDEADBEEF);
        drive_store(3, sn, a_s, d_s, s_s, w_s);
        checks++;
        if (sn !== 3 || a_s !== 32'h2000 || s_s !== 4'b1111 || w_s !== 1'b1) begin
            failures++;
            $display("FAIL sw_miss stall_n=%0d addr=%h strb=%b we=%b required 3 00002000 1111 1", sn, a_s, s_s, w_s);
        end
        next_cycle();
        set_req(1'b1, 1'b0, LW, 32'h2000, 32'h0);
        #1;
        checks++;
        if (cache_hit !== 1'b0 || stall !== 1'b1) begin
            failures++;
            $display("FAIL no_allocate hit=%b stall=%b required 0 1", cache_hit, stall);
        end
        drive_refill(1, beats, sn, a_s);
        checks++;
        if (sn !== 6 || a_s !== 32'h2000 || rdata !== 32'hA0 || cache_hit !== 1'b1) begin
            failures++;
            $display("FAIL refill_2000 stall_n=%0d addr=%h rdata=%h hit=%b required 6 00002000 000000a0 1", sn, a_s, rdata, cache_hit);
        end
        next_cycle();
    endtask

    task automatic test_misaligned();
        set_req(1'b1, 1'b0, LW, 32'h102, 32'h0);
        #1;
        checks++;
        if (misaligned !== 1'b1 || stall !== 1'b0 || rdata !== 32'h0 || cache_hit !== 1'b0) begin
            failures++;
            $display("FAIL mis_lw mis=%b stall=%b rdata=%h hit=%b required 1 0 0 0", misaligned, stall, rdata, cache_hit);
        end
        next_cycle();
        set_req(1'b1, 1'b1, SH, 32'h105, 32'h1);
        #1;
        checks++;
        if (misaligned !== 1'b1 || stall !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL mis_sh mis=%b stall=%b req=%b required 1 0 0", misaligned, stall, mem_bus.mem_req);
        end
        next_cycle();
        set_req(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
        #1;
        checks++;
        if (mem_bus.mem_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0 || misaligned !== 1'b0) begin
            failures++;
            $display("FAIL invalid_f3 req=%b stall=%b rdata=%h mis=%b required 0 0 0 0", mem_bus.mem_req, stall, rdata, misaligned);
        end
        next_cycle();
        set_req(1'b1, 1'b1, 3'b100, 32'h100, 32'h5);
        #1;
        checks++;
        if (stall !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL invalid_store stall=%b req=%b required 0 0", stall, mem_bus.mem_req);
        end
        next_cycle();
        set_req(1'b0, 1'b0, LW, 32'h100, 32'h0);
        #1;
        checks++;
        if (cache_hit !== 1'b0 || stall !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL no_valid hit=%b stall=%b req=%b required 0 0 0", cache_hit, stall, mem_bus.mem_req);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] beats [4];
        int sn;
        logic [31:0] a_s;
        beats[0] = 32'h5; beats[1] = 32'h6; beats[2] = 32'h7; beats[3] = 32'h8;
        set_req(1'b1, 1'b0, LW, 32'h300, 32'h0);
        next_cycle();
        mem_bus.mem_gnt = 1'b1;
        next_cycle();
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hBAD0;
        next_cycle();
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hBAD1;
        next_cycle();
        rst = 1'b1;
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hBAD2;
        #1;
        checks++;
        if (stall !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs stall=%b rdata=%h required 0 0", stall, rdata);
        end
        next_cycle();
        rst = 1'b0;
        req_valid = 1'b0;
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hBAD3;
        #1;
        checks++;
        if (mem_bus.mem_req !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_idle req=%b stall=%b required 0 0", mem_bus.mem_req, stall);
        end
        next_cycle();
        set_req(1'b1, 1'b0, LW, 32'h300, 32'h0);
        #1;
        checks++;
        if (cache_hit !== 1'b0 || stall !== 1'b1) begin
            failures++;
            $display("FAIL partial_line_invalid hit=%b stall=%b required 0 1", cache_hit, stall);
        end
        drive_refill(2, beats, sn, a_s);
        checks++;
        if (sn !== 7 || a_s !== 32'h300 || rdata !== 32'h5 || cache_hit !== 1'b1) begin
            failures++;
            $display("FAIL refill_after_rst stall_n=%0d addr=%h rdata=%h hit=%b required 7 00000300 00000005 1", sn, a_s, rdata, cache_hit);
        end
        next_cycle();
        set_req(1'b1, 1'b0, LW, 32'h30C, 32'h0);
        #1;
        checks++;
        if (rdata !== 32'h8 || cache_hit !== 1'b1) begin
            failures++;
            $display("FAIL refill_after_rst_w3 rdata=%h hit=%b required 00000008 1", rdata, cache_hit);
        end
        next_cycle();
        set_req(1'b1, 1'b0, LW, 32'h100, 32'h0);
        #1;
        checks++;
        if (cache_hit !== 1'b0 || stall !== 1'b1) begin
            failures++;
            $display("FAIL rst_invalidates hit=%b stall=%b required 0 1", cache_hit, stall);
        end
        rst = 1'b1;
        req_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_refill();
        test_load_align();
        test_store_merge();
        test_no_allocate();
        test_misaligned();
        test_reset_mid_refill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
